// File: rtl/pingpong_pkg.sv
// Shared definitions for the ping-pong bank scheduler.
//   DATA_W_DEF / DEPTH_DEF : default word width and words per bank
//   CNT_W                  : width of the drop and frame status counters
//   bank_t                 : bank index (two banks, one bit)
package pingpong_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 64;
  localparam int CNT_W      = 16;

  typedef logic bank_t;

endpackage

// File: rtl/pp_skid_fifo2.sv
// Two-entry output FIFO between the bank read port and the downstream stream.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data this cycle (caller guarantees room)
//   push_data  : word to store
//   pop        : remove the head this cycle (ignored when empty)
//   valid      : FIFO holds at least one word
//   head       : oldest stored word
//   count      : number of stored words, 0..2
// A push and a pop in the same cycle are both applied.
module pp_skid_fifo2
  import pingpong_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic              valid,
  output logic [DATA_W-1:0] head,
  output logic [1:0]        count
);

  logic [DATA_W-1:0] mem0;
  logic [DATA_W-1:0] mem1;
  logic              wr_ptr;
  logic              rd_ptr;
  logic              do_pop;

  assign do_pop = pop && (count != 2'd0);
  assign valid  = (count != 2'd0);
  assign head   = rd_ptr ? mem1 : mem0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0   <= '0;
      mem1   <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        if (wr_ptr) mem1 <= push_data;
        else        mem0 <= push_data;
        wr_ptr <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, do_pop};
    end
  end

endmodule

// File: rtl/pingpong_bank_sched.sv
// Controller for a two-bank ping-pong buffer built from two simple dual-port
// RAMs. The writer fills one bank while the reader drains the other through a
// valid/ready stream backed by a 2-entry FIFO.
// Ports:
//   clk, rst                    : clock, asynchronous active-high reset
//   wr_valid/wr_data/wr_ready   : input stream, word accepted on valid&&ready
//   ramN_wr_en/addr/data        : bank write port strobes
//   ramN_rd_en/addr, ramN_q     : bank read port, q valid 1 cycle after rd_en
//   rd_valid/rd_data/rd_ready   : output stream, transfer on valid&&ready
//   bank_full                   : per-bank full flags
//   drop_cnt                    : saturating count of wr_valid&&!wr_ready
//   frame_cnt                   : wrapping count of fully drained banks
// Handshake: a producer holds valid and data stable until ready is seen in the
// same cycle; a transfer happens on every rising edge with valid && ready.
module pingpong_bank_sched
  import pingpong_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_valid,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_ready,
  output logic              ram0_wr_en,
  output logic [ADDR_W-1:0] ram0_wr_addr,
  output logic [DATA_W-1:0] ram0_wr_data,
  output logic              ram1_wr_en,
  output logic [ADDR_W-1:0] ram1_wr_addr,
  output logic [DATA_W-1:0] ram1_wr_data,
  output logic              ram0_rd_en,
  output logic [ADDR_W-1:0] ram0_rd_addr,
  input  logic [DATA_W-1:0] ram0_q,
  output logic              ram1_rd_en,
  output logic [ADDR_W-1:0] ram1_rd_addr,
  input  logic [DATA_W-1:0] ram1_q,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  input  logic              rd_ready,
  output logic [1:0]        bank_full,
  output logic [CNT_W-1:0]  drop_cnt,
  output logic [CNT_W-1:0]  frame_cnt
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  bank_t             wbank;
  bank_t             rbank;
  bank_t             inflight_bank;
  logic              inflight;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic [1:0]        bank_full_next;
  logic              accept;
  logic              wr_last;
  logic              issue;
  logic              rd_last;
  logic              fifo_pop;
  logic [1:0]        fifo_count;
  logic [DATA_W-1:0] push_data;

  // Gating with rst keeps every write strobe low while reset is held.
  assign wr_ready = !rst && !bank_full[wbank];
  assign accept   = wr_valid && wr_ready;
  assign wr_last  = accept && (waddr == LAST_ADDR);
  assign fifo_pop = rd_valid && rd_ready;

  // Credit check: stored words plus the read in flight, minus the word leaving
  // this cycle, must leave room for the new read when its data lands. Counting
  // the pop is what lets the stream run at one word per cycle.
  assign issue   = bank_full[rbank] &&
                   (({1'b0, fifo_count} + {2'b00, inflight}) < (3'd2 + {2'b00, fifo_pop}));
  assign rd_last = issue && (raddr == LAST_ADDR);

  assign ram0_wr_en   = accept && (wbank == 1'b0);
  assign ram1_wr_en   = accept && (wbank == 1'b1);
  assign ram0_wr_addr = waddr;
  assign ram1_wr_addr = waddr;
  assign ram0_wr_data = wr_data;
  assign ram1_wr_data = wr_data;
  assign ram0_rd_en   = issue && (rbank == 1'b0);
  assign ram1_rd_en   = issue && (rbank == 1'b1);
  assign ram0_rd_addr = raddr;
  assign ram1_rd_addr = raddr;

  assign push_data = inflight_bank ? ram1_q : ram0_q;

  // Writer only sets a non-full bank, reader only clears a full one, so the
  // two updates never target the same flag.
  always_comb begin
    bank_full_next = bank_full;
    if (rd_last) bank_full_next[rbank] = 1'b0;
    if (wr_last) bank_full_next[wbank] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wbank         <= 1'b0;
      waddr         <= '0;
      rbank         <= 1'b0;
      raddr         <= '0;
      bank_full     <= 2'b00;
      inflight      <= 1'b0;
      inflight_bank <= 1'b0;
      drop_cnt      <= '0;
      frame_cnt     <= '0;
    end else begin
      bank_full     <= bank_full_next;
      inflight      <= issue;
      inflight_bank <= rbank;
      if (accept) begin
        waddr <= waddr + ADDR_W'(1);
        if (wr_last) wbank <= ~wbank;
      end
      if (issue) begin
        raddr <= raddr + ADDR_W'(1);
        if (rd_last) begin
          rbank     <= ~rbank;
          frame_cnt <= frame_cnt + CNT_W'(1);
        end
      end
      if (wr_valid && !wr_ready && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_W'(1);
    end
  end

  pp_skid_fifo2 #(.DATA_W(DATA_W)) u_out_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (inflight),
    .push_data (push_data),
    .pop       (fifo_pop),
    .valid     (rd_valid),
    .head      (rd_data),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_pingpong_bank_sched.sv
module tb_pingpong_bank_sched;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic [7:0]  wr_data;
  logic        wr_ready;
  logic        ram0_wr_en, ram1_wr_en;
  logic [5:0]  ram0_wr_addr, ram1_wr_addr;
  logic [7:0]  ram0_wr_data, ram1_wr_data;
  logic        ram0_rd_en, ram1_rd_en;
  logic [5:0]  ram0_rd_addr, ram1_rd_addr;
  logic [7:0]  ram0_q, ram1_q;
  logic        rd_valid;
  logic [7:0]  rd_data;
  logic        rd_ready;
  logic [1:0]  bank_full;
  logic [15:0] drop_cnt;
  logic [15:0] frame_cnt;

  // Behavioural RAM models
  logic [7:0] mem0 [64];
  logic [7:0] mem1 [64];

  logic [7:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int issue_cnt = 0;
  int xfer_cnt  = 0;
  int max_out   = 0;

  pingpong_bank_sched dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .ram0_wr_en   (ram0_wr_en),
    .ram0_wr_addr (ram0_wr_addr),
    .ram0_wr_data (ram0_wr_data),
    .ram1_wr_en   (ram1_wr_en),
    .ram1_wr_addr (ram1_wr_addr),
    .ram1_wr_data (ram1_wr_data),
    .ram0_rd_en   (ram0_rd_en),
    .ram0_rd_addr (ram0_rd_addr),
    .ram0_q       (ram0_q),
    .ram1_rd_en   (ram1_rd_en),
    .ram1_rd_addr (ram1_rd_addr),
    .ram1_q       (ram1_q),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .rd_ready     (rd_ready),
    .bank_full    (bank_full),
    .drop_cnt     (drop_cnt),
    .frame_cnt    (frame_cnt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached, required finish earlier");
    $fatal(1);
  end

  always @(posedge clk) begin
    if (ram0_wr_en) mem0[ram0_wr_addr] <= ram0_wr_data;
    if (ram1_wr_en) mem1[ram1_wr_addr] <= ram1_wr_data;
    if (ram0_rd_en) ram0_q <= mem0[ram0_rd_addr];
    if (ram1_rd_en) ram1_q <= mem1[ram1_rd_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // scoreboard monitor: sampled on the falling edge, the transfer it sees
  // completes on the next rising edge
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      issue_cnt = 0;
      xfer_cnt  = 0;
      max_out   = 0;
    end else begin
      if (issue_cnt - xfer_cnt > max_out) max_out = issue_cnt - xfer_cnt;
      if (wr_valid && wr_ready) exp_q.push_back(wr_data);
      if (ram0_rd_en || ram1_rd_en) issue_cnt++;
      if (rd_valid && rd_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL rd_spurious: got %0h, required no word", rd_data);
        end else begin
          check("rd_data", {24'b0, rd_data}, {24'b0, exp_q.pop_front()});
        end
      end
    end
  end

  // driver tasks
  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    wr_valid = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic drive_words(input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      wr_valid = 1'b1;
      wr_data  = base + 8'(i);
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int limit);
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !rd_valid) break;
    end
    check(name, exp_q.size(), 0);
  endtask

  int run;

  initial begin
    rst = 1'b1; wr_valid = 1'b1; wr_data = 8'h55; rd_ready = 1'b1;
    ram0_q = '0; ram1_q = '0;

    // reset state, with wr_valid held high to show strobes stay low
    @(negedge clk);
    check("rst_wr_en0", ram0_wr_en, 0);
    check("rst_rd_en", {ram0_rd_en, ram1_rd_en}, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_bank_full", bank_full, 0);
    check("rst_counters", {drop_cnt, frame_cnt}, 0);
    @(posedge clk); #1;
    rst = 1'b0; wr_valid = 1'b0;
    @(negedge clk);
    check("wr_ready_after_rst", wr_ready, 1);

    // one frame, rd_ready=1: latency 2 and consecutive output
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      wr_valid = 1'b1; wr_data = 8'(i);
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(negedge clk);
    check("t1_bank_full", bank_full, 2'b01);
    check("t1_lat_c0", rd_valid, 0);
    @(negedge clk);
    check("t1_lat_c1", rd_valid, 0);
    run = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (rd_valid) run++;
    end
    check("t1_consecutive", run, 64);
    @(negedge clk);
    check("t1_done_valid", rd_valid, 0);
    check("t1_frame_cnt", frame_cnt, 1);
    check("t1_queue", exp_q.size(), 0);

    // both banks full with rd_ready=0, then 10 drops
    do_reset();
    rd_ready = 1'b0;
    for (int i = 0; i < 138; i++) begin
      @(posedge clk); #1;
      wr_valid = 1'b1; wr_data = (i < 128) ? 8'(i) : 8'hAA;
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    @(negedge clk);
    check("t2_bank_full", bank_full, 2'b11);
    check("t2_wr_ready", wr_ready, 0);
    check("t2_drop_cnt", drop_cnt, 10);
    check("t2_rd_valid", rd_valid, 1);
    check("t2_rd_head", rd_data, 0);
    check("t2_no_issue", {ram0_rd_en, ram1_rd_en}, 0);

    // drain from full: bank 0 released one cycle after its last issue
    @(posedge clk); #1;
    rd_ready = 1'b1;
    run = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ram0_rd_en && ram0_rd_addr == 6'd63) begin run = 1; break; end
    end
    check("t3_last_issue_seen", run, 1);
    check("t3_wr_ready_before", wr_ready, 0);
    @(negedge clk);
    check("t3_wr_ready_after", wr_ready, 1);
    check("t3_bank_full", bank_full, 2'b10);
    wait_drain("t3_drain", 300);
    check("t3_frame_cnt", frame_cnt, 2);

    // rd_ready toggling during a frame
    do_reset();
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      rd_ready = ~i[0];
      wr_valid = (i < 64);
      wr_data  = 8'(i) + 8'h40;
      if (i >= 64 && xfer_cnt >= 64) break;
    end
    wr_valid = 1'b0; rd_ready = 1'b1;
    wait_drain("t4_drain", 20);
    check("t4_xfers", xfer_cnt, 64);
    check("t4_max_held", (max_out <= 2), 1);
    check("t4_frame_cnt", frame_cnt, 1);

    // reset mid-frame with a read in flight
    do_reset();
    for (int i = 0; i < 94; i++) begin
      @(posedge clk); #1;
      wr_valid = 1'b1; wr_data = 8'(i) ^ 8'h5A;
    end
    @(negedge clk);
    check("t5_busy_before_rst", rd_valid, 1);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    check("t5_rst_strobes", {ram0_wr_en, ram1_wr_en, ram0_rd_en, ram1_rd_en}, 0);
    check("t5_rst_rd_valid", rd_valid, 0);
    check("t5_rst_state", {wr_ready, bank_full, frame_cnt}, 0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0; wr_valid = 1'b0;
    run = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (rd_valid) run++;
    end
    check("t5_no_stale", run, 0);
    for (int i = 0; i < 64; i++) begin
      @(posedge clk); #1;
      wr_valid = 1'b1; wr_data = 8'(i) + 8'hC0;
      if (i == 0) begin
        @(negedge clk);
        check("t5_restart", {ram0_wr_en, ram1_wr_en, ram0_wr_addr}, {2'b10, 6'd0});
      end
    end
    @(posedge clk); #1;
    wr_valid = 1'b0;
    wait_drain("t5_drain", 200);
    check("t5_frame_cnt", frame_cnt, 1);

    // drop counter saturation: 128 accepts then 65545 drops in total
    do_reset();
    rd_ready = 1'b0;
    drive_words(128 + 65534, 8'h00);
    @(negedge clk);
    check("t6_drop_fffe", drop_cnt, 16'hFFFE);
    drive_words(11, 8'h00);
    @(negedge clk);
    check("t6_drop_sat", drop_cnt, 16'hFFFF);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
